// File: rtl/qam16_sym_sched.sv
// qam16_sym_sched: ROM bit sequencer and 4-bit symbol packer feeding the QAM16 mapper.
// Optional preamble build: define QAM16_PREAMBLE_EN.
//
// Ports:
//   CLK, Rst_n          clock, async active-low reset
//   start, stop         begin streaming / end streaming after current frame
//   rom_addr, rom_en    registered ROM address and live-read strobe
//   rom_q               ROM data, one cycle after rom_addr
//   sym_data/valid/ready symbol handshake (first-fetched bit in bit 3)
//   sym_sof, sym_eof    frame markers, qualified by sym_valid
//   busy, frame_cnt     not idle / completed-frame counter
module qam16_sym_sched #(
    parameter int ADDR_W     = 10,
    parameter int FRAME_BITS = 1024,
    parameter int GAP_CYC    = 16,
    parameter int PRE_SYMS   = 4
) (
    input  logic              CLK,
    input  logic              Rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic              rom_q,
    output logic [3:0]        sym_data,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic              sym_sof,
    output logic              sym_eof,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int NSYM = FRAME_BITS / 4;
`ifdef QAM16_PREAMBLE_EN
    localparam int PRE_N = PRE_SYMS;
`else
    localparam int PRE_N = 0;
`endif
    localparam int TOT = NSYM + PRE_N;
    localparam int SW  = $clog2(NSYM + PRE_SYMS + 1);
    localparam int GW  = $clog2(GAP_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_OUT   = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
`ifdef QAM16_PREAMBLE_EN
    localparam logic [2:0] S_PRE   = 3'd4;
    localparam logic [2:0] S_FIRST = S_PRE;
`else
    localparam logic [2:0] S_FIRST = S_FETCH;
`endif

    logic [2:0]    state;
    logic [2:0]    c;
    logic [2:0]    sh;
    logic [SW-1:0] sidx;
    logic [GW-1:0] gcnt;
    logic          stop_pend;
    logic          last;

    // Symbol index spans preamble plus data symbols of one frame.
    assign last   = (sidx == SW'(TOT - 1));
    assign rom_en = (state == S_FETCH) && (c != 3'd4);
    assign busy   = (state != S_IDLE);

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            c         <= 3'd0;
            sh        <= 3'd0;
            sidx      <= '0;
            gcnt      <= '0;
            stop_pend <= 1'b0;
            rom_addr  <= '0;
            sym_data  <= 4'd0;
            sym_valid <= 1'b0;
            sym_sof   <= 1'b0;
            sym_eof   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            if ((state != S_IDLE) && stop)
                stop_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    stop_pend <= 1'b0;
                    c         <= 3'd0;
                    sidx      <= '0;
                    if (start)
                        state <= S_FIRST;
                end

                S_FETCH: begin
                    // rom_q lags the address by one cycle, so bits land at c=1..4.
                    if (c != 3'd0)
                        sh <= {sh[1:0], rom_q};
                    if (c != 3'd4) begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        c        <= c + 3'd1;
                    end else begin
                        sym_data  <= {sh, rom_q};
                        sym_valid <= 1'b1;
                        sym_sof   <= (sidx == '0);
                        sym_eof   <= last;
                        c         <= 3'd0;
                        state     <= S_OUT;
                    end
                end

`ifdef QAM16_PREAMBLE_EN
                S_PRE: begin
                    sym_data  <= sidx[0] ? 4'h0 : 4'hF;
                    sym_valid <= 1'b1;
                    sym_sof   <= (sidx == '0);
                    sym_eof   <= last;
                    state     <= S_OUT;
                end
`endif

                S_OUT: begin
                    if (sym_ready) begin
                        sym_valid <= 1'b0;
                        sym_sof   <= 1'b0;
                        sym_eof   <= 1'b0;
                        if (last) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            sidx      <= '0;
                            gcnt      <= '0;
                            if (stop_pend || stop) begin
                                stop_pend <= 1'b0;
                                state     <= S_IDLE;
                            end else begin
                                state <= S_GAP;
                            end
                        end else begin
                            sidx <= sidx + SW'(1);
`ifdef QAM16_PREAMBLE_EN
                            if (int'(sidx) + 1 < PRE_N)
                                state <= S_PRE;
                            else
                                state <= S_FETCH;
`else
                            state <= S_FETCH;
`endif
                        end
                    end
                end

                S_GAP: begin
                    if (gcnt == GW'(GAP_CYC - 1)) begin
                        gcnt <= '0;
                        if (stop_pend || stop) begin
                            stop_pend <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_FIRST;
                        end
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/qam16_sym_sched.md
Name: qam16_sym_sched

Overview:
- Sequencer between the bit-source ROM and the QAM16 mapper in the send chain.
- Generates ROM addresses and packs four serial ROM bits, MSB first, into one 4-bit symbol.
- Presents each symbol on a valid/ready interface with start-of-frame and end-of-frame markers.
- Controls frame boundaries, inter-frame gaps and start/stop of streaming.

Parameters:
- ADDR_W, 10, ROM address width; address wraps modulo 2^ADDR_W.
- FRAME_BITS, 1024, data bits per frame; must be a multiple of 4 and ≥4; FRAME_BITS/4 symbols per frame.
- GAP_CYC, 16, idle cycles between frames in continuous streaming; must be ≥1.
- PRE_SYMS, 4, preamble symbols per frame; used only with QAM16_PREAMBLE_EN.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; sampled only in IDLE; begins streaming.
- stop  in  1  request to end streaming after the current frame; latched as stop_pend.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_en  out  1  high in cycles where rom_addr is a live read.
- rom_q  in  1  ROM data; value in cycle n+1 = ROM[rom_addr in cycle n].
- sym_data  out  4  symbol, first-fetched bit in bit 3.
- sym_valid  out  1  symbol valid.
- sym_ready  in  1  mapper accepts; handshake = sym_valid & sym_ready at a rising edge.
- sym_sof  out  1  first symbol of frame; qualified by sym_valid.
- sym_eof  out  1  last symbol of frame; qualified by sym_valid.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  completed frames; +1 on each eof handshake; wraps.

Behaviour:
- Reset, at any time including mid-frame: state=IDLE; rom_addr=0, rom_en=0, sym_data=0, sym_valid=0, sym_sof=0, sym_eof=0, frame_cnt=0, stop_pend=0, shift reg=0, counters=0. A partially built symbol is discarded.
- IDLE:
  - start=1 → FETCH with c=0. start while not IDLE is ignored.
  - stop in IDLE clears stop_pend. start and stop together in IDLE: start wins, stop_pend=0.
- FETCH, sub-counter c=0..4, 5 cycles:
  - rom_en=1 at c=0..3. rom_addr=a+c for c=0..3.
  - rom_addr increments on each c→c+1 edge for c=0..3, so it equals a+4 at c=4.
  - At c=1..4 rom_q is shifted into the shift reg LSB-in.
  - At the c=4 edge: sym_data←{sh[2:0],rom_q}, sym_valid←1, sof/eof set from the symbol index → OUT.
- OUT:
  - sym_valid, sym_data, sof and eof are held stable until handshake. rom_addr is held, rom_en=0.
  - On handshake: sym_valid←0, sof/eof←0.
  - If not the last symbol → FETCH.
  - If last: frame_cnt+1. If stop_pend → IDLE (stop_pend cleared). Otherwise → GAP.
- GAP: exactly GAP_CYC cycles, then FETCH. A stop arriving during GAP → IDLE at the end of the gap.
- stop=1 in any non-IDLE state sets stop_pend. The current frame always completes through its eof handshake; frames are never truncated.
- Latency and throughput:
  - sym_valid rises 5 edges after the edge sampling start.
  - With sym_ready=1, symbol period is 6 cycles.
  - With sym_ready=1, from an eof handshake to the next FETCH c=0 takes GAP_CYC cycles.
- Address continuity: rom_addr is not reset between frames. It continues across frames and restarts and wraps 2^ADDR_W−1→0 without a glitch, including inside a symbol.
- FRAME_BITS=4: sof and eof are both asserted on the single symbol.

Optional Feature:
- QAM16_PREAMBLE_EN defined:
  - Each frame starts with PRE_SYMS preamble symbols alternating 4'hF, 4'h0, starting with 4'hF.
  - Each preamble symbol takes 1 cycle to load, then the normal OUT handshake.
  - No ROM reads during preamble; rom_en=0 and rom_addr unchanged.
  - sym_sof is on the first preamble symbol, not on data.
- QAM16_PREAMBLE_EN undefined: no preamble logic; sym_sof is on the first data symbol.

Test Plan:
- Common bench: ROM model with bits at addresses 0..7 = 1,0,1,1,0,0,1,0; FRAME_BITS=16, GAP_CYC=3, sym_ready=1 unless stated.
- Reset check: assert Rst_n=0 mid-FETCH → all outputs 0 immediately. Release, wait 10 cycles → sym_valid=0, busy=0.
- Single-shot start + stop: start pulse with stop=1 one cycle later → first sym_valid 5 edges after start with sym_data=4'hB, sof=1; next symbol 4'h2 6 cycles later; 4 symbols total; eof on the 4th; then IDLE, frame_cnt=1, rom_addr=16.
- Backpressure: sym_ready=0 for 10 cycles while sym_valid=1 → sym_data, sof/eof and rom_addr stable, rom_en=0. Release → handshake, next symbol 6 cycles later.
- Continuous wrap with ADDR_W=4: no stop → frames 1 and 2 separated by 3 GAP cycles. Frame 2 reads addresses 0..15 again (wrap 15→0) and reproduces symbols 4'hB, 4'h2. stop during GAP → IDLE after the gap, frame_cnt=2.
- Preamble, with QAM16_PREAMBLE_EN, PRE_SYMS=4: sequence F,0,F,0,B,2,… → sof on the first F, eof on the 8th symbol, no rom_en during the first 4 symbols. Without the macro → sof on B.
